// File: rtl/tt_sweep_if.sv
// Bundle between the sweep/capture stage and whoever runs it.
// Carries the start/done/busy handshake, the captured truth-table results
// and the stimulus/response pair (vec, f_in) of the combinational block.
// Optional self-check signals (expected, mismatch, first_bad) are present
// only when TT_SWEEP_CHECK_EN is defined.
//   master : sweep host side (drives start, f_in, expected)
//   slave  : tt_sweep_capture side
interface tt_sweep_if #(
  parameter int unsigned N_IN = 5
) ();

  localparam int unsigned TBL_W = 2**N_IN;

  logic              start;
  logic [N_IN-1:0]   vec;
  logic              f_in;
  logic              busy;
  logic              done;
  logic [TBL_W-1:0]  table_out;
  logic              valid;
  logic [N_IN:0]     ones_count;
`ifdef TT_SWEEP_CHECK_EN
  logic [TBL_W-1:0]  expected;
  logic              mismatch;
  logic [N_IN-1:0]   first_bad;
`endif

`ifdef TT_SWEEP_CHECK_EN
  modport master (
    output start, f_in, expected,
    input  vec, busy, done, table_out, valid, ones_count, mismatch, first_bad
  );

  modport slave (
    input  start, f_in, expected,
    output vec, busy, done, table_out, valid, ones_count, mismatch, first_bad
  );
`else
  modport master (
    output start, f_in,
    input  vec, busy, done, table_out, valid, ones_count
  );

  modport slave (
    input  start, f_in,
    output vec, busy, done, table_out, valid, ones_count
  );
`endif

endinterface

// File: rtl/tt_sweep_capture.sv
// Truth-table sweep and capture stage for an N_IN-input combinational block.
// On an accepted start it drives every input combination onto vec in
// ascending order, holds each one SETTLE cycles, samples f_in and writes the
// sample into table_out[vec]. A one-cycle done pulse marks completion, after
// which table_out/ones_count/valid hold until the next accepted start.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous reset, active-low
//   bus.start  sweep request, only sampled in IDLE
//   bus.vec    stimulus to the block (MSB drives A, LSB drives E)
//   bus.f_in   block output F
//   bus.busy   high from the cycle after start through the FINISH cycle
//   bus.done   one-cycle completion pulse
//   bus.table_out / bus.valid / bus.ones_count  captured results
//
// Optional macro TT_SWEEP_CHECK_EN adds bus.expected (reference table),
// bus.mismatch and bus.first_bad (index of the first differing vector).
//
// SETTLE must be in 1..15; each vector occupies SETTLE+1 cycles.
module tt_sweep_capture #(
  parameter int unsigned N_IN   = 5,
  parameter int unsigned SETTLE = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  tt_sweep_if.slave bus
);

  localparam int unsigned TBL_W   = 2**N_IN;
  localparam int unsigned ONES_W  = N_IN + 1;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned VEC_MAX = TBL_W - 1;

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE - 1);
  localparam logic [N_IN-1:0]  VEC_LAST   = N_IN'(VEC_MAX);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_FINISH
  } state_t;

  state_t             state_q, state_d;
  logic [N_IN-1:0]    vec_q, vec_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               valid_q, valid_d;
  logic [TBL_W-1:0]   table_q, table_d;
  logic [ONES_W-1:0]  ones_q, ones_d;
`ifdef TT_SWEEP_CHECK_EN
  logic               mismatch_q, mismatch_d;
  logic [N_IN-1:0]    first_bad_q, first_bad_d;
`endif

  // State and output registers; reset wins over any sweep in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      vec_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
      table_q     <= '0;
      ones_q      <= '0;
`ifdef TT_SWEEP_CHECK_EN
      mismatch_q  <= 1'b0;
      first_bad_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      valid_q     <= valid_d;
      table_q     <= table_d;
      ones_q      <= ones_d;
`ifdef TT_SWEEP_CHECK_EN
      mismatch_q  <= mismatch_d;
      first_bad_q <= first_bad_d;
`endif
    end
  end

  // Next-state and next-output logic. Outputs are computed one cycle ahead
  // so that done/valid/vec=0 are already visible during the FINISH cycle.
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    valid_d     = valid_q;
    table_d     = table_q;
    ones_d      = ones_q;
`ifdef TT_SWEEP_CHECK_EN
    mismatch_d  = mismatch_q;
    first_bad_d = first_bad_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          table_d     = '0;
          ones_d      = '0;
          valid_d     = 1'b0;
          vec_d       = '0;
          cnt_d       = CNT_RELOAD;
          busy_d      = 1'b1;
`ifdef TT_SWEEP_CHECK_EN
          mismatch_d  = 1'b0;
          first_bad_d = '0;
`endif
          state_d     = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_CAPTURE: begin
        table_d[vec_q] = bus.f_in;
        if (bus.f_in) begin
          ones_d = ones_q + ONES_W'(1);
        end
`ifdef TT_SWEEP_CHECK_EN
        // Only the first miss records its index.
        if ((bus.f_in != bus.expected[vec_q]) && !mismatch_q) begin
          mismatch_d  = 1'b1;
          first_bad_d = vec_q;
        end
`endif
        if (vec_q == VEC_LAST) begin
          done_d  = 1'b1;
          valid_d = 1'b1;
          vec_d   = '0;
          state_d = ST_FINISH;
        end else begin
          vec_d   = vec_q + N_IN'(1);
          cnt_d   = CNT_RELOAD;
          state_d = ST_SETTLE;
        end
      end

      ST_FINISH: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.vec        = vec_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.valid      = valid_q;
  assign bus.table_out  = table_q;
  assign bus.ones_count = ones_q;
`ifdef TT_SWEEP_CHECK_EN
  assign bus.mismatch   = mismatch_q;
  assign bus.first_bad  = first_bad_q;
`endif

endmodule
